// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl
// Purpose  : Sequences trap entry and exit for decoded ecall, mret and illegal
//            instructions. It sits beside the ID stage, holds IF/ID, waits for
//            older instructions to drain, writes mepc/mcause/mtval through the
//            shared CSR write port, then redirects fetch and flushes IF/ID.
// Ports    : clk, rst_n (sync, active low)
//            id_valid, id_pc, ir, is_ecall, is_mret, is_illegal_ir,
//            is_e_cause_eq_ecall, pipe_empty, mtvec, mepc       (inputs)
//            stall, busy, csr_wr_en, csr_wr_addr, csr_wr_data,
//            redirect, redirect_pc, flush, trap_taken           (outputs)
// Revision : 1.0 - initial release
// ============================================================================
module trap_ctrl #(
  parameter logic [11:0] MEPC_ADDR   = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR = 12'h342,
  parameter logic [11:0] MTVAL_ADDR  = 12'h343
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] ir,
  input  logic        is_ecall,
  input  logic        is_mret,
  input  logic        is_illegal_ir,
  input  logic        is_e_cause_eq_ecall,
  input  logic        pipe_empty,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        stall,
  output logic        busy,
  output logic        csr_wr_en,
  output logic [11:0] csr_wr_addr,
  output logic [31:0] csr_wr_data,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        trap_taken
);

  localparam logic [3:0] c_CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] c_CAUSE_ECALL   = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRAIN   = 3'd1,
    S_W_EPC   = 3'd2,
    S_W_CAUSE = 3'd3,
    S_W_TVAL  = 3'd4,
    S_REDIR   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [3:0]  r_cause;
  logic        r_kind;    // 0: trap entry, 1: mret
  logic        r_ret4;    // mret resumes after the ecall that trapped

  logic        w_accept;
  logic [3:0]  w_cause;
  logic        w_kind;

  // Only IDLE accepts; anything arriving later stays parked in ID by stall.
  assign w_accept = (r_state == S_IDLE) & id_valid &
                    (is_illegal_ir | is_ecall | is_mret);

  // Priority illegal > ecall > mret. An mret carries no cause.
  always_comb begin
    w_cause = 4'd0;
    w_kind  = 1'b0;
    if (is_illegal_ir) begin
      w_cause = c_CAUSE_ILLEGAL;
    end else if (is_ecall) begin
      w_cause = c_CAUSE_ECALL;
    end else begin
      w_kind  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= 32'd0;
      r_ir    <= 32'd0;
      r_cause <= 4'd0;
      r_kind  <= 1'b0;
      r_ret4  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_pc    <= id_pc;
        r_ir    <= ir;
        r_cause <= w_cause;
        r_kind  <= w_kind;
        r_ret4  <= is_mret & ~is_illegal_ir & ~is_ecall & is_e_cause_eq_ecall;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    csr_wr_en    = 1'b0;
    csr_wr_addr  = 12'd0;
    csr_wr_data  = 32'd0;
    redirect     = 1'b0;
    redirect_pc  = 32'd0;
    flush        = 1'b0;
    trap_taken   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        // mret writes no CSRs, so it goes straight to the redirect.
        if (pipe_empty) w_next_state = r_kind ? S_REDIR : S_W_EPC;
      end
      S_W_EPC: begin
        csr_wr_en    = 1'b1;
        csr_wr_addr  = MEPC_ADDR;
        csr_wr_data  = r_pc;
        w_next_state = S_W_CAUSE;
      end
      S_W_CAUSE: begin
        csr_wr_en    = 1'b1;
        csr_wr_addr  = MCAUSE_ADDR;
        csr_wr_data  = {28'd0, r_cause};
        w_next_state = S_W_TVAL;
      end
      S_W_TVAL: begin
        csr_wr_en    = 1'b1;
        csr_wr_addr  = MTVAL_ADDR;
        csr_wr_data  = (r_cause == c_CAUSE_ILLEGAL) ? r_ir : 32'd0;
        w_next_state = S_REDIR;
      end
      S_REDIR: begin
        redirect     = 1'b1;
        flush        = 1'b1;
        if (r_kind) begin
          // mepc is read live here; the 32-bit add wraps naturally.
          redirect_pc = r_ret4 ? (mepc + 32'd4) : mepc;
        end else begin
          // Direct mode only: the low mode bits of mtvec are masked off.
          redirect_pc = mtvec & 32'hFFFF_FFFC;
          trap_taken  = 1'b1;
        end
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign busy  = (r_state != S_IDLE);
  assign stall = busy | w_accept;

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_ctrl
// Purpose  : Directed, table-driven bench for trap_ctrl. Each table row holds
//            one cycle of inputs and the outputs expected before the next
//            clock edge; a hand-written sequence covers a long drain.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] ir;
  logic        is_ecall;
  logic        is_mret;
  logic        is_illegal_ir;
  logic        is_e_cause_eq_ecall;
  logic        pipe_empty;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        stall;
  logic        busy;
  logic        csr_wr_en;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        trap_taken;

  int checks;
  int failures;

  trap_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .id_valid            (id_valid),
    .id_pc               (id_pc),
    .ir                  (ir),
    .is_ecall            (is_ecall),
    .is_mret             (is_mret),
    .is_illegal_ir       (is_illegal_ir),
    .is_e_cause_eq_ecall (is_e_cause_eq_ecall),
    .pipe_empty          (pipe_empty),
    .mtvec               (mtvec),
    .mepc                (mepc),
    .stall               (stall),
    .busy                (busy),
    .csr_wr_en           (csr_wr_en),
    .csr_wr_addr         (csr_wr_addr),
    .csr_wr_data         (csr_wr_data),
    .redirect            (redirect),
    .redirect_pc         (redirect_pc),
    .flush               (flush),
    .trap_taken          (trap_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed output bundle: stall,busy,wen,addr[12],wdata[32],redir,rpc[32],flush,tt
  typedef struct {
    logic        rst_n, vld, ill, ec, mr, fl, pe;
    logic [31:0] pc, ir, mepc;
    logic [81:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic void add(
    input logic r, input logic v, input logic il, input logic e, input logic m,
    input logic f, input logic p, input logic [31:0] pc_i, input logic [31:0] ir_i,
    input logic [31:0] mepc_i, input logic st, input logic bu, input logic we,
    input logic [11:0] a, input logic [31:0] d, input logic rd,
    input logic [31:0] rp, input logic fo, input logic tt);
    vec_t x;
    x.rst_n = r; x.vld = v; x.ill = il; x.ec = e; x.mr = m; x.fl = f; x.pe = p;
    x.pc = pc_i; x.ir = ir_i; x.mepc = mepc_i;
    x.exp = {st, bu, we, a, d, rd, rp, fo, tt};
    vq.push_back(x);
  endfunction

  function automatic logic [81:0] outs();
    return {stall, busy, csr_wr_en, csr_wr_addr, csr_wr_data,
            redirect, redirect_pc, flush, trap_taken};
  endfunction

  task automatic check(input string name, input logic [81:0] act, input logic [81:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    id_valid = 1'b0; is_ecall = 1'b0; is_mret = 1'b0; is_illegal_ir = 1'b0;
    is_e_cause_eq_ecall = 1'b0; id_pc = 32'd0; ir = 32'd0;
  endtask

  localparam logic [31:0] MT = 32'h8000_0000;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; pipe_empty = 1'b1; mtvec = 32'h8000_0003; mepc = 32'd0;
    idle_inputs();

    // ---- ecall pc=0x100
    add(1,1,0,1,0,0,1,'h100,'h73,0,        1,0,0,'h000,'h0,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,0,               1,1,0,'h000,'h0,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,0,               1,1,1,'h341,'h100,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,0,               1,1,1,'h342,'d11,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,0,               1,1,1,'h343,'h0,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,0,               1,1,0,'h000,'h0,1,MT,1,1);
    add(1,0,0,0,0,0,1,0,0,0,               0,0,0,'h000,'h0,0,0,0,0);
    // ---- illegal+ecall together (illegal wins); ecall while busy ignored
    add(1,1,1,1,0,0,1,'h200,'hFFFFFFFF,0,  1,0,0,'h000,'h0,0,0,0,0);
    add(1,1,0,1,0,0,1,'h500,'h73,0,        1,1,0,'h000,'h0,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,0,               1,1,1,'h341,'h200,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,0,               1,1,1,'h342,'d2,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,0,               1,1,1,'h343,'hFFFFFFFF,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,0,               1,1,0,'h000,'h0,1,MT,1,1);
    add(1,0,0,0,0,0,1,0,0,0,               0,0,0,'h000,'h0,0,0,0,0);
    // ---- mret, resume after ecall -> mepc+4
    add(1,1,0,0,1,1,1,'h180,'h30200073,'h100, 1,0,0,'h000,'h0,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,'h100,           1,1,0,'h000,'h0,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,'h100,           1,1,0,'h000,'h0,1,'h104,1,0);
    add(1,0,0,0,0,0,1,0,0,'h100,           0,0,0,'h000,'h0,0,0,0,0);
    // ---- mret, plain return -> mepc
    add(1,1,0,0,1,0,1,'h180,'h30200073,'h100, 1,0,0,'h000,'h0,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,'h100,           1,1,0,'h000,'h0,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,'h100,           1,1,0,'h000,'h0,1,'h100,1,0);
    add(1,0,0,0,0,0,1,0,0,'h100,           0,0,0,'h000,'h0,0,0,0,0);
    // ---- mret +4 wraps at 32 bits
    add(1,1,0,0,1,1,1,'h180,'h30200073,'hFFFFFFFC, 1,0,0,'h000,'h0,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,'hFFFFFFFC,      1,1,0,'h000,'h0,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,'hFFFFFFFC,      1,1,0,'h000,'h0,1,'h0,1,0);
    add(1,0,0,0,0,0,1,0,0,'hFFFFFFFC,      0,0,0,'h000,'h0,0,0,0,0);
    // ---- ecall pc=0x300, pipe busy 3 cycles in DRAIN
    add(1,1,0,1,0,0,0,'h300,'h73,0,        1,0,0,'h000,'h0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,0,               1,1,0,'h000,'h0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,0,               1,1,0,'h000,'h0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,0,               1,1,0,'h000,'h0,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,0,               1,1,0,'h000,'h0,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,0,               1,1,1,'h341,'h300,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,0,               1,1,1,'h342,'d11,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,0,               1,1,1,'h343,'h0,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,0,               1,1,0,'h000,'h0,1,MT,1,1);
    add(1,0,0,0,0,0,1,0,0,0,               0,0,0,'h000,'h0,0,0,0,0);
    // ---- reset during W_CAUSE abandons the sequence; next ecall runs cleanly
    add(1,1,0,1,0,0,1,'h380,'h73,0,        1,0,0,'h000,'h0,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,0,               1,1,0,'h000,'h0,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,0,               1,1,1,'h341,'h380,0,0,0,0);
    add(0,0,0,0,0,0,1,0,0,0,               1,1,1,'h342,'d11,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,0,               0,0,0,'h000,'h0,0,0,0,0);
    add(1,1,0,1,0,0,1,'h400,'h73,0,        1,0,0,'h000,'h0,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,0,               1,1,0,'h000,'h0,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,0,               1,1,1,'h341,'h400,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,0,               1,1,1,'h342,'d11,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,0,               1,1,1,'h343,'h0,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,0,               1,1,0,'h000,'h0,1,MT,1,1);
    add(1,0,0,0,0,0,1,0,0,0,               0,0,0,'h000,'h0,0,0,0,0);

    // Reset and check the reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", outs(), 82'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      rst_n = vq[i].rst_n; id_valid = vq[i].vld; is_illegal_ir = vq[i].ill;
      is_ecall = vq[i].ec; is_mret = vq[i].mr; is_e_cause_eq_ecall = vq[i].fl;
      pipe_empty = vq[i].pe; id_pc = vq[i].pc; ir = vq[i].ir; mepc = vq[i].mepc;
      @(negedge clk);
      check($sformatf("vec%0d", i), outs(), vq[i].exp);
      @(posedge clk); #1;
    end

    // Hand sequence: illegal with a different mtvec and a 5-cycle drain.
    rst_n = 1'b1; idle_inputs(); mtvec = 32'h1234_5677; mepc = 32'd0;
    id_valid = 1'b1; is_illegal_ir = 1'b1; id_pc = 32'h600; ir = 32'hDEAD_BEEF;
    pipe_empty = 1'b0;
    @(negedge clk);
    check("long_accept_stall", {81'd0, stall}, 82'd1);
    @(posedge clk); #1;
    idle_inputs();
    begin
      int first_wen, redir_cyc, wen_cnt;
      logic [31:0] tval, rpc;
      first_wen = -1; redir_cyc = -1; wen_cnt = 0; tval = 32'd0; rpc = 32'd0;
      for (int k = 1; k <= 40 && redir_cyc < 0; k++) begin
        pipe_empty = (k >= 6);
        @(negedge clk);
        if (csr_wr_en) begin
          wen_cnt++;
          if (first_wen < 0) first_wen = k;
          if (csr_wr_addr == 12'h343) tval = csr_wr_data;
        end
        if (redirect) begin
          redir_cyc = k;
          rpc = redirect_pc;
        end
        @(posedge clk); #1;
      end
      check("long_first_wen_cycle", 82'(first_wen), 82'd7);
      check("long_redirect_cycle", 82'(redir_cyc), 82'd10);
      check("long_wen_count", 82'(wen_cnt), 82'd3);
      check("long_mtval", 82'(tval), 82'hDEAD_BEEF);
      check("long_redirect_pc", 82'(rpc), 82'h1234_5674);
    end
    @(negedge clk);
    check("long_back_idle", outs(), 82'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
